// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package ctrl_pkg;

    // Sequencer states; the encoding is exported on state_o for debug.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Legal opcodes occupy the two low bits; any set bit above them is illegal.
    localparam logic [1:0] OP_R   = 2'd0;
    localparam logic [1:0] OP_LW  = 2'd1;
    localparam logic [1:0] OP_SW  = 2'd2;
    localparam logic [1:0] OP_BEQ = 2'd3;

    // ALU operation selects.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Bundle of every datapath control produced by the sequencer.
    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       illegal_op;
        logic       timeout;
    } ctrl_t;

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive cycles spent waiting on a memory ready and flags the
// cycle on which the wait budget runs out. TIMEOUT=0 disables the timer.
module wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic wait_en,
    input  logic ready,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_inert
            // Wait forever: no counter, never expires.
            assign expired = 1'b0;
        end else begin : g_count
            localparam int unsigned CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

            logic [CW-1:0] cnt_reg;

            // Wait-cycle counter: restarts on state entry or ready, saturates.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (clear || ready) begin
                    cnt_reg <= '0;
                end else if (wait_en && (cnt_reg != SAT)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // A ready arriving on the last allowed cycle still completes normally.
            assign expired = wait_en && !ready && (cnt_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    input  logic            zero,
    output logic            imem_req,
    output logic            ir_write,
    output logic            pc_write,
    output logic            pc_src,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src,
    output logic [1:0]      alu_op,
    output logic            branch,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            illegal_op,
    output logic            timeout,
    output logic [2:0]      state_o
);

    state_t          state_reg;
    state_t          state_next;
    logic [OP_W-1:0] op_q_reg;
    logic            run_q_reg;
    ctrl_t           ctrl_next;
    ctrl_t           ctrl_out;
    logic            op_illegal;
    logic            wait_en;
    logic            wait_ready;
    logic            wait_clear;
    logic            wait_expired;

    // Opcodes with any bit set above the two legal bits are illegal.
    generate
        if (OP_W > 2) begin : g_wide_op
            assign op_illegal = |op[OP_W-1:2];
        end else begin : g_narrow_op
            assign op_illegal = 1'b0;
        end
    endgenerate

    // The timer only runs while a request is outstanding.
    assign wait_en    = run_q_reg && ((state_reg == ST_FETCH) || (state_reg == ST_MEM));
    assign wait_ready = (state_reg == ST_FETCH) ? imem_ready : dmem_ready;
    assign wait_clear = (state_next != state_reg) || ctrl_next.timeout;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .wait_en (wait_en),
        .ready   (wait_ready),
        .expired (wait_expired)
    );

    // State, latched opcode and the run flag that holds off the first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FETCH;
            op_q_reg  <= '0;
            run_q_reg <= 1'b0;
        end else begin
            run_q_reg <= 1'b1;
            if (run_q_reg) begin
                state_reg <= state_next;
                if (state_reg == ST_DECODE) begin
                    op_q_reg <= op;
                end
            end
        end
    end

    // Next-state and control decode from state, opcode, zero and ready inputs.
    always_comb begin
        state_next = state_reg;
        ctrl_next  = '0;
        case (state_reg)
            ST_FETCH: begin
                ctrl_next.imem_req = 1'b1;
                if (imem_ready) begin
                    ctrl_next.ir_write = 1'b1;
                    ctrl_next.pc_write = 1'b1;
                    state_next         = ST_DECODE;
                end else if (wait_expired) begin
                    ctrl_next.timeout = 1'b1;
                    state_next        = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // PC was already advanced in FETCH, so an illegal op just refetches.
                if (op_illegal) begin
                    ctrl_next.illegal_op = 1'b1;
                    state_next           = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q_reg[1:0])
                    OP_R: begin
                        ctrl_next.alu_op = ALU_FUNCT;
                        state_next       = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        ctrl_next.alu_op  = ALU_ADD;
                        ctrl_next.alu_src = 1'b1;
                        state_next        = ST_MEM;
                    end
                    default: begin
                        // BEQ: the PC update follows the live zero flag.
                        ctrl_next.alu_op   = ALU_SUB;
                        ctrl_next.branch   = 1'b1;
                        ctrl_next.pc_write = zero;
                        ctrl_next.pc_src   = 1'b1;
                        state_next         = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                if (op_q_reg[1:0] == OP_LW) begin
                    ctrl_next.mem_read = 1'b1;
                end else begin
                    ctrl_next.mem_write = 1'b1;
                end
                if (dmem_ready) begin
                    state_next = (op_q_reg[1:0] == OP_LW) ? ST_WB : ST_FETCH;
                end else if (wait_expired) begin
                    ctrl_next.timeout = 1'b1;
                    state_next        = ST_FETCH;
                end
            end
            ST_WB: begin
                ctrl_next.reg_write = 1'b1;
                if (op_q_reg[1:0] == OP_LW) begin
                    ctrl_next.mem_to_reg = 1'b1;
                end else begin
                    ctrl_next.reg_dst = 1'b1;
                end
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Outputs are forced low until the first edge after reset release.
    assign ctrl_out   = run_q_reg ? ctrl_next : '0;
    assign imem_req   = ctrl_out.imem_req;
    assign ir_write   = ctrl_out.ir_write;
    assign pc_write   = ctrl_out.pc_write;
    assign pc_src     = ctrl_out.pc_src;
    assign reg_dst    = ctrl_out.reg_dst;
    assign reg_write  = ctrl_out.reg_write;
    assign alu_src    = ctrl_out.alu_src;
    assign alu_op     = ctrl_out.alu_op;
    assign branch     = ctrl_out.branch;
    assign mem_read   = ctrl_out.mem_read;
    assign mem_write  = ctrl_out.mem_write;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign illegal_op = ctrl_out.illegal_op;
    assign timeout    = ctrl_out.timeout;
    assign state_o    = run_q_reg ? state_reg : 3'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle directed bench for the multi-cycle control sequencer.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [2:0] op;
    logic       imem_ready;
    logic       dmem_ready;
    logic       zero;
    logic       imem_req, ir_write, pc_write, pc_src, reg_dst, reg_write, alu_src;
    logic [1:0] alu_op;
    logic       branch, mem_read, mem_write, mem_to_reg, illegal_op, timeout;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    // Expected-control masks, bit order matches the packed comparison word.
    localparam logic [14:0] IMREQ   = 15'h4000;
    localparam logic [14:0] IRW     = 15'h2000;
    localparam logic [14:0] PCW     = 15'h1000;
    localparam logic [14:0] PCSRC   = 15'h0800;
    localparam logic [14:0] RDST    = 15'h0400;
    localparam logic [14:0] RWR     = 15'h0200;
    localparam logic [14:0] ASRC    = 15'h0100;
    localparam logic [14:0] AOP_FN  = 15'h0080;
    localparam logic [14:0] AOP_SUB = 15'h0040;
    localparam logic [14:0] BR      = 15'h0020;
    localparam logic [14:0] MRD     = 15'h0010;
    localparam logic [14:0] MWR     = 15'h0008;
    localparam logic [14:0] M2R     = 15'h0004;
    localparam logic [14:0] ILL     = 15'h0002;
    localparam logic [14:0] TMO     = 15'h0001;
    localparam logic [14:0] NONE    = 15'h0000;
    localparam logic [14:0] FETCHED = IMREQ | IRW | PCW;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        ir;
        logic        dr;
        logic        z;
        logic [2:0]  st;
        logic [14:0] ctl;
    } vec_t;

    vec_t tv[$];

    multicycle_control #(
        .OP_W    (3),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .zero       (zero),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .timeout    (timeout),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void add(string name, logic [2:0] o, logic ir, logic dr, logic z,
                                logic [2:0] st, logic [14:0] ctl);
        vec_t v;
        v.name = name; v.op = o; v.ir = ir; v.dr = dr; v.z = z; v.st = st; v.ctl = ctl;
        tv.push_back(v);
    endfunction

    task automatic compare(string name, logic [2:0] st, logic [14:0] ctl);
        logic [17:0] got;
        logic [17:0] exp;
        got = {state_o, imem_req, ir_write, pc_write, pc_src, reg_dst, reg_write, alu_src,
               alu_op, branch, mem_read, mem_write, mem_to_reg, illegal_op, timeout};
        exp = {st, ctl};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d ctl=%h, want state=%0d ctl=%h",
                     name, got[17:15], got[14:0], st, ctl);
        end else begin
            $display("ok   %s: state=%0d ctl=%h", name, got[17:15], got[14:0]);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), check mid-cycle.
    task automatic step(string name, logic [2:0] o, logic ir, logic dr, logic z,
                        logic [2:0] st, logic [14:0] ctl);
        op = o; imem_ready = ir; dmem_ready = dr; zero = z;
        @(negedge clk);
        compare(name, st, ctl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name, op, imem_ready, dmem_ready, zero, state, controls
        add("reset_cycle1",    0, 1, 0, 0, 0, NONE);
        add("r_fetch",         0, 1, 0, 0, 0, FETCHED);
        add("r_decode",        0, 0, 0, 0, 1, NONE);
        add("r_exec",          0, 0, 0, 0, 2, AOP_FN);
        add("r_wb",            0, 0, 0, 0, 4, RWR | RDST);
        add("lw_fetch",        0, 1, 0, 0, 0, FETCHED);
        add("lw_decode",       1, 0, 0, 0, 1, NONE);
        add("lw_exec",         0, 0, 0, 0, 2, ASRC);
        add("lw_mem_wait1",    0, 0, 0, 0, 3, MRD);
        add("lw_mem_wait2",    0, 0, 0, 0, 3, MRD);
        add("lw_mem_wait3",    0, 0, 0, 0, 3, MRD);
        add("lw_mem_ready4",   0, 0, 1, 0, 3, MRD);
        add("lw_wb",           0, 0, 0, 0, 4, RWR | M2R);
        add("sw_fetch",        0, 1, 0, 0, 0, FETCHED);
        add("sw_decode",       2, 0, 0, 0, 1, NONE);
        add("sw_exec",         0, 0, 0, 0, 2, ASRC);
        add("sw_mem",          0, 0, 1, 0, 3, MWR);
        add("beq1_fetch",      0, 1, 0, 0, 0, FETCHED);
        add("beq1_decode",     3, 0, 0, 0, 1, NONE);
        add("beq1_exec_z1",    0, 0, 0, 1, 2, AOP_SUB | BR | PCW | PCSRC);
        add("beq0_fetch",      0, 1, 0, 0, 0, FETCHED);
        add("beq0_decode",     3, 0, 0, 0, 1, NONE);
        add("beq0_exec_z0",    0, 0, 0, 0, 2, AOP_SUB | BR | PCSRC);
        add("ill_fetch",       0, 1, 0, 0, 0, FETCHED);
        add("ill_decode_op5",  5, 0, 0, 0, 1, ILL);
        add("ill_refetch",     0, 1, 0, 0, 0, FETCHED);
        add("r2_decode",       0, 0, 0, 0, 1, NONE);
        add("r2_exec",         0, 0, 0, 0, 2, AOP_FN);
        add("r2_wb",           0, 0, 0, 0, 4, RWR | RDST);
        add("lwto_fetch",      0, 1, 0, 0, 0, FETCHED);
        add("lwto_decode",     1, 0, 0, 0, 1, NONE);
        add("lwto_exec",       0, 0, 0, 0, 2, ASRC);
        add("lwto_mem1",       0, 0, 0, 0, 3, MRD);
        add("lwto_mem2",       0, 0, 0, 0, 3, MRD);
        add("lwto_mem3",       0, 0, 0, 0, 3, MRD);
        add("lwto_mem4_tmo",   0, 0, 0, 0, 3, MRD | TMO);
        add("fto_fetch1",      0, 0, 0, 0, 0, IMREQ);
        add("fto_fetch2",      0, 0, 0, 0, 0, IMREQ);
        add("fto_fetch3",      0, 0, 0, 0, 0, IMREQ);
        add("fto_fetch4_tmo",  0, 0, 0, 0, 0, IMREQ | TMO);
        add("swlate_fetch",    0, 1, 0, 0, 0, FETCHED);
        add("swlate_decode",   2, 0, 0, 0, 1, NONE);
        add("swlate_exec",     0, 0, 0, 0, 2, ASRC);
        add("swlate_mem1",     0, 0, 0, 0, 3, MWR);
        add("swlate_mem2",     0, 0, 0, 0, 3, MWR);
        add("swlate_mem3",     0, 0, 0, 0, 3, MWR);
        add("swlate_mem4_rdy", 0, 0, 1, 0, 3, MWR);
        add("after_sw_fetch",  0, 1, 0, 0, 0, FETCHED);

        rst_n = 1'b0; op = 0; imem_ready = 1'b1; dmem_ready = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("in_reset", 3'd0, NONE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].name, tv[i].op, tv[i].ir, tv[i].dr, tv[i].z, tv[i].st, tv[i].ctl);
        end

        // Reset asserted while a data read is outstanding drops it at once.
        step("mid_decode",     1, 0, 0, 0, 1, NONE);
        step("mid_exec",       0, 0, 0, 0, 2, ASRC);
        step("mid_mem",        0, 0, 0, 0, 3, MRD);
        rst_n = 1'b0;
        #1;
        compare("async_reset_drop", 3'd0, NONE);
        @(posedge clk);
        #1;
        compare("held_in_reset", 3'd0, NONE);
        rst_n = 1'b1;
        step("rerelease_cycle1", 0, 1, 0, 0, 0, NONE);
        step("rerelease_fetch",  0, 1, 0, 0, 0, FETCHED);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
